// File: rtl/vga_text_renderer_pkg.sv
// Shared timing constants, pipeline stage record and video-memory address helper
// for the 80x30 text-mode VGA renderer.
package vga_text_renderer_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int COLS      = 80;
    localparam int ROWS      = 30;
    localparam int CELL_W    = 8;
    localparam int CELL_H    = 16;
    localparam int PIPE_LAT  = 3;
    localparam int BLINK_BIT = 4;

    typedef struct packed {
        logic       active;
        logic       hs;
        logic       vs;
        logic       cursor;
        logic [2:0] px;
    } stage_t;

    localparam stage_t STAGE_RESET = '{active: 1'b0, hs: 1'b1, vs: 1'b1, cursor: 1'b0, px: 3'd0};

    // row*80 + col built from shifts so no multiplier is inferred
    function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
        logic [11:0] r;
        r = {7'd0, row};
        return (r << 6) + (r << 4) + {5'd0, col};
    endfunction

endpackage

// File: rtl/vga_text_renderer_timing.sv
// Raster counters (h, v, frame) plus raw sync, active window and frame wrap strobe.
// Latency: combinational decode of the current counter value; no backpressure, free-running.
module vga_text_renderer_timing #(
    parameter int H_VISIBLE = vga_text_renderer_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_text_renderer_pkg::H_FRONT,
    parameter int H_SYNC    = vga_text_renderer_pkg::H_SYNC,
    parameter int H_BACK    = vga_text_renderer_pkg::H_BACK,
    parameter int V_VISIBLE = vga_text_renderer_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_text_renderer_pkg::V_FRONT,
    parameter int V_SYNC    = vga_text_renderer_pkg::V_SYNC,
    parameter int V_BACK    = vga_text_renderer_pkg::V_BACK,
    parameter int BLINK_BIT = vga_text_renderer_pkg::BLINK_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [6:0] col,
    output logic [2:0] px,
    output logic [4:0] row,
    output logic [3:0] glyph_row,
    output logic       blink,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       active,
    output logic       frame_wrap
);

    localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [5:0] frame_cnt;
    logic       line_end;

    assign line_end   = (h_cnt == H_LAST);
    assign frame_wrap = line_end && (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
        end else begin
            h_cnt <= line_end ? 10'd0 : h_cnt + 10'd1;
            if (frame_wrap) begin
                v_cnt     <= '0;
                frame_cnt <= frame_cnt + 6'd1;
            end else if (line_end) begin
                v_cnt <= v_cnt + 10'd1;
            end
        end
    end

    assign hs_raw    = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign vs_raw    = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    assign active    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign col       = h_cnt[9:3];
    assign px        = h_cnt[2:0];
    assign row       = v_cnt[8:4];
    assign glyph_row = v_cnt[3:0];
    assign blink     = frame_cnt[BLINK_BIT];

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode VGA read side: raster walk, video-memory and font fetch, mono pixel out.
// Latency: pixel/hsync/vsync are exactly 3 clocks behind the counters; no backpressure.
module vga_text_renderer #(
    parameter int H_VISIBLE = vga_text_renderer_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_text_renderer_pkg::H_FRONT,
    parameter int H_SYNC    = vga_text_renderer_pkg::H_SYNC,
    parameter int H_BACK    = vga_text_renderer_pkg::H_BACK,
    parameter int V_VISIBLE = vga_text_renderer_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_text_renderer_pkg::V_FRONT,
    parameter int V_SYNC    = vga_text_renderer_pkg::V_SYNC,
    parameter int V_BACK    = vga_text_renderer_pkg::V_BACK,
    parameter int BLINK_BIT = vga_text_renderer_pkg::BLINK_BIT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [11:0] vmem_addr,
    input  logic [7:0]  vmem_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic        hsync,
    output logic        vsync,
    output logic        pixel
);
    import vga_text_renderer_pkg::*;

    logic [6:0] col;
    logic [2:0] px;
    logic [4:0] row;
    logic [3:0] glyph_row;
    logic       blink;
    logic       hs_raw;
    logic       vs_raw;
    logic       active;
    logic       frame_wrap;

    vga_text_renderer_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .BLINK_BIT (BLINK_BIT)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .col        (col),
        .px         (px),
        .row        (row),
        .glyph_row  (glyph_row),
        .blink      (blink),
        .hs_raw     (hs_raw),
        .vs_raw     (vs_raw),
        .active     (active),
        .frame_wrap (frame_wrap)
    );

    // Cursor is sampled only at the frame boundary so a frame never shows a torn cursor
    logic       sh_en;
    logic [6:0] sh_col;
    logic [4:0] sh_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_en  <= 1'b0;
            sh_col <= '0;
            sh_row <= '0;
        end else if (frame_wrap) begin
            sh_en  <= cursor_en;
            sh_col <= cursor_col;
            sh_row <= cursor_row;
        end
    end

    stage_t     s0;
    stage_t     s1;
    stage_t     s2;
    logic [3:0] glyph_row_d1;
    logic       cursor_hit;
    logic       glyph_bit;

    assign cursor_hit = sh_en && (col == sh_col) && (row == sh_row)
                        && (glyph_row[3:1] == 3'b111) && blink;

    assign s0 = '{active: active, hs: hs_raw, vs: vs_raw, cursor: cursor_hit, px: px};

    assign vmem_addr = active ? cell_addr(row, col) : 12'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1           <= STAGE_RESET;
            s2           <= STAGE_RESET;
            glyph_row_d1 <= '0;
        end else begin
            s1           <= s0;
            s2           <= s1;
            glyph_row_d1 <= glyph_row;
        end
    end

    // Gating on the delayed active flag keeps the font address quiet in blanking and reset
    assign font_addr = s1.active ? {vmem_data, glyph_row_d1} : 12'd0;
    assign glyph_bit = font_data[3'd7 - s2.px];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel <= 1'b0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            pixel <= s2.active & (glyph_bit | s2.cursor);
            hsync <= s2.hs;
            vsync <= s2.vs;
        end
    end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench: a full-size 640x480 instance for line timing and glyph fetch, and a
// shrunken-raster instance (120x60, blink bit 1) so vsync, cursor and blink fit in a short run.
module tb_vga_text_renderer;
    import vga_text_renderer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int t;
    int tests;
    int fails;

    logic [11:0] f_vmem_addr, f_font_addr;
    logic [7:0]  f_vmem_data, f_font_data;
    logic        f_hsync, f_vsync, f_pixel;
    logic [7:0]  f_vmem [0:4095];
    logic [7:0]  f_font [0:4095];

    logic [11:0] s_vmem_addr, s_font_addr;
    logic [7:0]  s_vmem_data, s_font_data;
    logic        s_hsync, s_vsync, s_pixel;
    logic        s_cur_en;
    logic [6:0]  s_cur_col;
    logic [4:0]  s_cur_row;

    vga_text_renderer dut_full (
        .clk        (clk),
        .rst_n      (rst_n),
        .vmem_addr  (f_vmem_addr),
        .vmem_data  (f_vmem_data),
        .font_addr  (f_font_addr),
        .font_data  (f_font_data),
        .cursor_en  (1'b1),
        .cursor_col (7'd80),
        .cursor_row (5'd0),
        .hsync      (f_hsync),
        .vsync      (f_vsync),
        .pixel      (f_pixel)
    );

    vga_text_renderer #(
        .H_VISIBLE (80), .H_FRONT (8), .H_SYNC (16), .H_BACK (16),
        .V_VISIBLE (48), .V_FRONT (4), .V_SYNC (2),  .V_BACK (6),
        .BLINK_BIT (1)
    ) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .vmem_addr  (s_vmem_addr),
        .vmem_data  (s_vmem_data),
        .font_addr  (s_font_addr),
        .font_data  (s_font_data),
        .cursor_en  (s_cur_en),
        .cursor_col (s_cur_col),
        .cursor_row (s_cur_row),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .pixel      (s_pixel)
    );

    // 1-cycle-latency memory models
    always @(posedge clk) begin
        f_vmem_data <= f_vmem[f_vmem_addr];
        f_font_data <= f_font[f_font_addr];
    end
    assign s_vmem_data = 8'h00;
    assign s_font_data = 8'h00;

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic wait_to(input int target);
        while (t < target) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    initial begin
        int low_cnt;
        tests = 0;
        fails = 0;
        t     = 0;
        for (int i = 0; i < 4096; i++) begin
            f_vmem[i] = 8'h00;
            f_font[i] = 8'h00;
        end
        f_vmem[0] = 8'h41;
        for (int r = 0; r < 16; r++) f_font[12'h410 + r] = 8'h81;
        s_cur_en  = 1'b1;
        s_cur_col = 7'd5;
        s_cur_row = 5'd2;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hsync", f_hsync, 1);
        check("rst_vsync", f_vsync, 1);
        check("rst_pixel", f_pixel, 0);
        check("rst_vmem_addr", f_vmem_addr, 0);
        check("rst_font_addr", f_font_addr, 0);
        check("rst_s_vsync", s_vsync, 1);
        rst_n = 1'b1;
        t = 0;

        // glyph 0x41 row 0 = 0x81 at cell (0,0)
        wait_to(1);  check("font_addr_cell0", f_font_addr, 12'h410);
        wait_to(2);  check("px_before_lat", f_pixel, 0);
        wait_to(PIPE_LAT); check("px_x0", f_pixel, 1);
        for (int x = 1; x <= 6; x++) begin
            wait_to(x + PIPE_LAT);
            check("px_x1_6", f_pixel, 0);
        end
        wait_to(7 + PIPE_LAT); check("px_x7", f_pixel, 1);
        wait_to(8 + PIPE_LAT); check("px_x8", f_pixel, 0);

        wait_to(90);  check("s_hsync_pre", s_hsync, 1);
        wait_to(91);  check("s_hsync_fall", s_hsync, 0);
        wait_to(632); check("vmem_addr_632_0", f_vmem_addr, 79);
        wait_to(640); check("vmem_addr_hblank", f_vmem_addr, 0);
        wait_to(658); check("hsync_pre", f_hsync, 1);
        wait_to(659); check("hsync_fall", f_hsync, 0);
        wait_to(754); check("hsync_low_end", f_hsync, 0);
        wait_to(755); check("hsync_rise", f_hsync, 1);
        wait_to(802); check("px_line0_tail", f_pixel, 0);
        wait_to(803); check("px_line1_x0", f_pixel, 1);
        wait_to(1458); check("hsync_l1_pre", f_hsync, 1);
        wait_to(1459); check("hsync_l1_fall", f_hsync, 0);
        wait_to(1928); check("s_vmem_addr_8_16", s_vmem_addr, 81);

        wait_to(5719); check("s_vmem_addr_max", s_vmem_addr, 169);
        wait_to(5720); check("s_vmem_addr_hblank", s_vmem_addr, 0);
        wait_to(5760); check("s_vmem_addr_vblank", s_vmem_addr, 0);
        wait_to(6242); check("s_vsync_pre", s_vsync, 1);
        wait_to(6243); check("s_vsync_fall", s_vsync, 0);
        wait_to(6482); check("s_vsync_low_end", s_vsync, 0);
        wait_to(6483); check("s_vsync_rise", s_vsync, 1);

        wait_to(12763); check("s_cursor_blink_off_f1", s_pixel, 0);
        wait_to(12800); check("vmem_addr_0_16", f_vmem_addr, 80);
        wait_to(12808); check("vmem_addr_8_16", f_vmem_addr, 81);
        wait_to(13442); check("s_vsync_f1_pre", s_vsync, 1);
        wait_to(13443); check("s_vsync_f1_fall", s_vsync, 0);

        // Mid-frame cursor move must not show until the next frame
        wait_to(15000);
        s_cur_col = 7'd7;
        wait_to(19843); check("s_cursor_row13", s_pixel, 0);
        wait_to(19962); check("s_cursor_x39", s_pixel, 0);
        wait_to(19963); check("s_cursor_x40", s_pixel, 1);
        wait_to(19970); check("s_cursor_x47", s_pixel, 1);
        wait_to(19971); check("s_cursor_x48", s_pixel, 0);
        wait_to(20083); check("s_cursor_line47", s_pixel, 1);
        wait_to(27163); check("s_cursor_old_pos_f3", s_pixel, 0);
        wait_to(27179); check("s_cursor_new_pos_f3", s_pixel, 1);
        wait_to(34379); check("s_cursor_blink_off_f4", s_pixel, 0);

        // Reset in the middle of an hsync pulse
        wait_to(35900); check("hsync_before_rst", f_hsync, 0);
        rst_n = 1'b0;
        #1;
        check("rst_async_hsync", f_hsync, 1);
        check("rst_async_pixel", f_pixel, 0);
        check("rst_async_vmem_addr", f_vmem_addr, 0);
        check("rst_async_font_addr", f_font_addr, 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t = 0;
        low_cnt = 0;
        while (t < 658) begin
            tick();
            if (f_hsync !== 1'b1) low_cnt++;
            if (t == PIPE_LAT) check("restart_px_x0", f_pixel, 1);
        end
        check("no_runt_hsync", low_cnt, 0);
        wait_to(659); check("restart_hsync_fall", f_hsync, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
